// File: rtl/ysyx_24080006_if_stage.sv
// Multi-cycle instruction fetch stage: one AXI4 single-beat read per instruction, then hand-off to IDU
// and wait for the EXU commit. Optional fetch-fault reporting is enabled by YSYX_IFU_FAULT_EN.
module ysyx_24080006_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        ifu2idu_valid,
  input  logic        idu2ifu_ready,
  output logic [31:0] ifu_pc,
  output logic [31:0] ifu_inst,
  output logic        ifu_fault,
  input  logic        exu2ifu_valid,
  output logic        ifu2exu_ready,
  input  logic [31:0] exu_dnpc,
  input  logic        exu_jump,
  input  logic        exu_branch,
  input  logic        exu_flush,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_AR,
    S_R,
    S_HOLD,
    S_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        fault_q, fault_d;

  logic        fetch_fault;
  logic [31:0] fetch_word;
  logic [31:0] fetch_addr;
  logic [31:0] next_pc;
  logic        unused_ok;

`ifdef YSYX_IFU_FAULT_EN
  // A faulting fetch is turned into an ecall so the EXU traps on it.
  assign fetch_fault = (rresp != 2'b00) || (pc_q[1:0] != 2'b00);
  assign fetch_word  = fetch_fault ? 32'h0000_0073 : rdata;
  assign fetch_addr  = {pc_q[31:2], 2'b00};
  assign unused_ok   = rlast;
`else
  assign fetch_fault = 1'b0;
  assign fetch_word  = rdata;
  assign fetch_addr  = pc_q;
  assign unused_ok   = ^{rlast, rresp};
`endif

  assign next_pc = (exu_jump | exu_branch | exu_flush) ? exu_dnpc : pc_q + 32'd4;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
    end
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    unique case (state_q)
      S_BOOT: state_d = S_AR;
      S_AR:   if (arready) state_d = S_R;
      S_R: begin
        if (rvalid) begin
          inst_d  = fetch_word;
          fault_d = fetch_fault;
          state_d = S_HOLD;
        end
      end
      S_HOLD: if (idu2ifu_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (exu2ifu_valid) begin
          pc_d    = next_pc;
          state_d = S_AR;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    arvalid       = 1'b0;
    rready        = 1'b0;
    ifu2idu_valid = 1'b0;
    ifu2exu_ready = 1'b0;
    unique case (state_q)
      S_AR:    arvalid       = 1'b1;
      S_R:     rready        = 1'b1;
      S_HOLD:  ifu2idu_valid = 1'b1;
      S_WAIT:  ifu2exu_ready = 1'b1;
      default: ;
    endcase
  end

  assign araddr    = fetch_addr;
  assign arlen     = 8'd0;
  assign arsize    = 3'b010;
  assign arburst   = 2'b01;
  assign ifu_pc    = pc_q;
  assign ifu_inst  = inst_q;
  assign ifu_fault = fault_q;

endmodule

// File: tb/tb_ysyx_24080006_if_stage.sv
// Bench for ysyx_24080006_if_stage: transaction-level model of the fetch loop checked every cycle,
// directed scenarios with literal expectations, then randomized handshakes and redirects.
module tb_ysyx_24080006_if_stage;

  localparam logic [31:0] RESET_PC = 32'h3000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ifu2idu_valid, idu2ifu_ready;
  logic [31:0] ifu_pc, ifu_inst;
  logic        ifu_fault;
  logic        exu2ifu_valid, ifu2exu_ready;
  logic [31:0] exu_dnpc;
  logic        exu_jump, exu_branch, exu_flush;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  ysyx_24080006_if_stage #(.RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset),
    .ifu2idu_valid(ifu2idu_valid), .idu2ifu_ready(idu2ifu_ready),
    .ifu_pc(ifu_pc), .ifu_inst(ifu_inst), .ifu_fault(ifu_fault),
    .exu2ifu_valid(exu2ifu_valid), .ifu2exu_ready(ifu2exu_ready),
    .exu_dnpc(exu_dnpc), .exu_jump(exu_jump), .exu_branch(exu_branch), .exu_flush(exu_flush),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clock = ~clock;

  // Where the instruction transaction currently stands, from the bench's point of view.
  typedef enum {P_BOOT, P_FETCH, P_DATA, P_HOLD, P_COMMIT} phase_e;

  typedef struct {
    logic        ar_rdy;
    logic        r_vld;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        idu_rdy;
    logic        exu_vld;
    logic        jmp;
    logic        br;
    logic        fl;
    logic [31:0] dnpc;
  } stim_t;

  phase_e      ph;
  logic [31:0] exp_pc;
  logic [31:0] exp_inst;
  logic        exp_fault;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_araddr(input logic [31:0] pc);
`ifdef YSYX_IFU_FAULT_EN
    return {pc[31:2], 2'b00};
`else
    return pc;
`endif
  endfunction

  function automatic stim_t quiet();
    stim_t s;
    s.ar_rdy = 1'b0; s.r_vld = 1'b0; s.r_data = 32'd0; s.r_resp = 2'b00;
    s.idu_rdy = 1'b0; s.exu_vld = 1'b0;
    s.jmp = 1'b0; s.br = 1'b0; s.fl = 1'b0; s.dnpc = 32'd0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t       s;
    logic [31:0] t;
    s.ar_rdy  = 1'($urandom_range(0, 1));
    s.r_vld   = 1'($urandom_range(0, 1));
    s.r_data  = $urandom;
    s.r_resp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
    s.idu_rdy = 1'($urandom_range(0, 1));
    s.exu_vld = 1'($urandom_range(0, 1));
    s.jmp     = ($urandom_range(0, 3) == 0);
    s.br      = ($urandom_range(0, 3) == 0);
    s.fl      = ($urandom_range(0, 7) == 0);
    t         = $urandom;
    s.dnpc    = ($urandom_range(0, 7) == 0) ? t : {t[31:2], 2'b00};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    arready       = s.ar_rdy;
    rvalid        = s.r_vld;
    rdata         = s.r_data;
    rresp         = s.r_resp;
    rlast         = s.r_vld;
    idu2ifu_ready = s.idu_rdy;
    exu2ifu_valid = s.exu_vld;
    exu_jump      = s.jmp;
    exu_branch    = s.br;
    exu_flush     = s.fl;
    exu_dnpc      = s.dnpc;
  endtask

  task automatic check_outputs();
    logic [3:0] hs;
    case (ph)
      P_FETCH:  hs = 4'b1000;
      P_DATA:   hs = 4'b0100;
      P_HOLD:   hs = 4'b0010;
      P_COMMIT: hs = 4'b0001;
      default:  hs = 4'b0000;
    endcase
    check("valid_ready{ar,r,idu,exu}", {28'd0, arvalid, rready, ifu2idu_valid, ifu2exu_ready},
          {28'd0, hs});
    if (ph == P_FETCH) check("araddr", araddr, exp_araddr(exp_pc));
    if (ph == P_HOLD || ph == P_COMMIT) begin
      check("ifu_pc", ifu_pc, exp_pc);
      check("ifu_inst", ifu_inst, exp_inst);
      check("ifu_fault", {31'd0, ifu_fault}, {31'd0, exp_fault});
    end
  endtask

  // One clock: compare outputs against the model, apply inputs, advance the model to the
  // transaction state the coming edge must produce.
  task automatic step(input stim_t s);
    @(negedge clock);
    check_outputs();
    drive(s);
    case (ph)
      P_BOOT:  ph = P_FETCH;
      P_FETCH: if (s.ar_rdy) ph = P_DATA;
      P_DATA: begin
        if (s.r_vld) begin
`ifdef YSYX_IFU_FAULT_EN
          exp_fault = (s.r_resp != 2'b00) || (exp_pc[1:0] != 2'b00);
`else
          exp_fault = 1'b0;
`endif
          exp_inst = exp_fault ? 32'h0000_0073 : s.r_data;
          ph = P_HOLD;
        end
      end
      P_HOLD:  if (s.idu_rdy) ph = P_COMMIT;
      P_COMMIT: begin
        if (s.exu_vld) begin
          exp_pc = (s.jmp || s.br || s.fl) ? s.dnpc : exp_pc + 32'd4;
          ph = P_FETCH;
        end
      end
      default: ph = P_BOOT;
    endcase
  endtask

  task automatic idle_fetch();
    step(quiet());
  endtask

  task automatic do_fetch(input logic [31:0] data, input logic [1:0] resp);
    stim_t s;
    s = quiet();
    s.ar_rdy = 1'b1;
    step(s);
    s = quiet();
    s.r_vld = 1'b1; s.r_data = data; s.r_resp = resp;
    step(s);
    step(quiet());
  endtask

  task automatic do_commit(input logic jmp, input logic br, input logic fl,
                           input logic [31:0] dnpc);
    stim_t s;
    s = quiet();
    s.idu_rdy = 1'b1;
    step(s);
    s = quiet();
    s.exu_vld = 1'b1; s.jmp = jmp; s.br = br; s.fl = fl; s.dnpc = dnpc;
    step(s);
  endtask

  initial begin
    stim_t s;
    drive(quiet());
    ph = P_BOOT; exp_pc = RESET_PC; exp_inst = 32'd0; exp_fault = 1'b0;

    // Reset values and AXI tie-offs.
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid_ready", {28'd0, arvalid, rready, ifu2idu_valid, ifu2exu_ready}, 32'd0);
    check("rst_pc", ifu_pc, 32'h3000_0000);
    check("rst_inst", ifu_inst, 32'd0);
    check("rst_fault", {31'd0, ifu_fault}, 32'd0);
    check("ar_tieoffs", {19'd0, arlen, arsize, arburst}, {19'd0, 8'd0, 3'b010, 2'b01});
    reset = 1'b0;

    // First fetch after reset.
    step(quiet());
    idle_fetch();
    check("first_araddr", araddr, 32'h3000_0000);
    do_fetch(32'h0000_0013, 2'b00);
    check("first_pc", ifu_pc, 32'h3000_0000);
    check("first_inst", ifu_inst, 32'h0000_0013);
    do_commit(1'b0, 1'b0, 1'b0, 32'hDEAD_0000);
    idle_fetch();
    check("seq_araddr", araddr, 32'h3000_0004);

    // Sequential wrap at the top of the address space.
    do_fetch($urandom, 2'b00);
    do_commit(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
    idle_fetch();
    check("jump_araddr", araddr, 32'hFFFF_FFFC);
    do_fetch($urandom, 2'b00);
    do_commit(1'b0, 1'b0, 1'b0, 32'h1234_5678);
    idle_fetch();
    check("wrap_araddr", araddr, 32'h0000_0000);

    // Redirects: taken branch, then jump and flush together.
    do_fetch($urandom, 2'b00);
    do_commit(1'b0, 1'b1, 1'b0, 32'h8000_0100);
    idle_fetch();
    check("branch_araddr", araddr, 32'h8000_0100);
    do_fetch($urandom, 2'b00);
    do_commit(1'b1, 1'b0, 1'b1, 32'h8000_0100);
    idle_fetch();
    check("jump_flush_araddr", araddr, 32'h8000_0100);

    // Back-pressure on every handshake, with a stray R beat while holding.
    s = quiet();
    repeat (5) step(s);
    s.ar_rdy = 1'b1; step(s);
    s = quiet();
    repeat (2) step(s);
    s.r_vld = 1'b1; s.r_data = 32'h00A0_0513; step(s);
    s = quiet();
    s.r_vld = 1'b1; s.r_data = 32'hBAD0_BAD0;
    repeat (3) step(s);
    s = quiet(); s.idu_rdy = 1'b1; step(s);
    s = quiet();
    repeat (4) step(s);
    check("bp_inst", ifu_inst, 32'h00A0_0513);
    s.exu_vld = 1'b1; step(s);

    // Error response on the R channel.
    do_fetch(32'hDEAD_BEEF, 2'b10);
`ifdef YSYX_IFU_FAULT_EN
    check("slverr_fault", {31'd0, ifu_fault}, 32'd1);
    check("slverr_inst", ifu_inst, 32'h0000_0073);
`else
    check("slverr_fault", {31'd0, ifu_fault}, 32'd0);
    check("slverr_inst", ifu_inst, 32'hDEAD_BEEF);
`endif
    do_commit(1'b0, 1'b0, 1'b0, 32'd0);

    // Asynchronous reset while waiting for the R beat.
    s = quiet(); s.ar_rdy = 1'b1; step(s);
    step(quiet());
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid_ready", {28'd0, arvalid, rready, ifu2idu_valid, ifu2exu_ready}, 32'd0);
    check("async_rst_pc", ifu_pc, 32'h3000_0000);
    check("async_rst_inst", ifu_inst, 32'd0);
    ph = P_BOOT; exp_pc = RESET_PC; exp_inst = 32'd0; exp_fault = 1'b0;
    s = quiet(); s.r_vld = 1'b1; s.r_data = 32'hFFFF_FFFF;
    drive(s);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    step(s);
    s.ar_rdy = 1'b1; step(s);
    s = quiet(); s.r_vld = 1'b1; s.r_data = 32'h0000_0093; step(s);
    step(quiet());
    check("restart_pc", ifu_pc, 32'h3000_0000);
    check("restart_inst", ifu_inst, 32'h0000_0093);
    do_commit(1'b0, 1'b0, 1'b0, 32'd0);

    // Randomized handshakes, data, responses and redirects.
    for (int i = 0; i < 3000; i++) step(rand_stim());

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
